// File: rtl/bram_loader_if.sv
// rtl/bram_loader_if.sv - byte stream in, BRAM write port and boot status out.
interface bram_loader_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic              wren;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic              cpu_rst_n;

  modport master (
    output rx_data, rx_valid,
    input  addr, din, wren, busy, done, error, err_code, cpu_rst_n
  );

  modport slave (
    input  rx_data, rx_valid,
    output addr, din, wren, busy, done, error, err_code, cpu_rst_n
  );
endinterface

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - boot loader: count-prefixed byte frame to BRAM words with XOR check.
module bram_loader #(
  parameter int ADDR_W      = 13,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic          clk,
  input logic          rst_n,
  bram_loader_if.slave bus
);
  localparam int MAX_WORDS = ((1 << ADDR_W) - BASE_ADDR) / 4;
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, CNT_LO, DATA, CHECK, DONE, ERROR} state_t;

  state_t          state, state_next;
  logic [1:0]      code_next;
  logic [7:0]      cnt_hi;
  logic [15:0]     n_words;
  logic [15:0]     word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     shift;
  logic [7:0]      csum;
  logic [TW-1:0]   tmo_cnt;
  logic [15:0]     count_in;
  logic            in_frame;
  logic            timeout;

  assign count_in = {cnt_hi, bus.rx_data};
  assign in_frame = (state == CNT_LO) || (state == DATA) || (state == CHECK);
  // A byte arriving on the would-be timeout clock wins over the timeout.
  assign timeout  = in_frame && !bus.rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    code_next  = bus.err_code;
    case (state)
      IDLE: if (bus.rx_valid) state_next = CNT_LO;
      CNT_LO: begin
        if (bus.rx_valid) begin
          if (count_in == 16'd0 || 32'(count_in) > 32'(MAX_WORDS)) begin
            state_next = ERROR;
            code_next  = 2'b01;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (bus.rx_valid && byte_idx == 2'd3 && word_idx == n_words - 16'd1)
          state_next = CHECK;
      end
      CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum) begin
            state_next = DONE;
          end else begin
            state_next = ERROR;
            code_next  = 2'b10;
          end
        end
      end
      default: ;
    endcase
    if (timeout) begin
      state_next = ERROR;
      code_next  = 2'b11;
    end
  end

  always_comb begin
    bus.busy      = in_frame;
    bus.done      = (state == DONE);
    bus.error     = (state == ERROR);
    bus.cpu_rst_n = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.err_code <= 2'b00;
      bus.addr     <= ADDR_W'(BASE_ADDR);
      bus.din      <= 32'd0;
      bus.wren     <= 1'b0;
      cnt_hi       <= 8'd0;
      n_words      <= 16'd0;
      word_idx     <= 16'd0;
      byte_idx     <= 2'd0;
      shift        <= 24'd0;
      csum         <= 8'd0;
      tmo_cnt      <= '0;
    end else begin
      bus.err_code <= code_next;
      bus.wren     <= 1'b0;
      if (bus.wren) bus.addr <= bus.addr + ADDR_W'(4);
      if (!in_frame || bus.rx_valid) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + TW'(1);
      if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            cnt_hi   <= bus.rx_data;
            csum     <= 8'd0;
            byte_idx <= 2'd0;
            word_idx <= 16'd0;
          end
          CNT_LO: n_words <= count_in;
          DATA: begin
            shift    <= {shift[15:0], bus.rx_data};
            csum     <= csum ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.din  <= {shift, bus.rx_data};
              bus.wren <= 1'b1;
              word_idx <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bram_loader.sv
// tb/tb_bram_loader.sv - randomized frames against a byte-position model of the loader.
module tb_bram_loader;
  localparam int ADDR_W = 13;
  localparam int BASE   = 0;
  localparam int TMO    = 100;
  localparam int MAXW   = ((1 << ADDR_W) - BASE) / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bram_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 0;

  // Model: frame progress tracked purely by how many bytes have been accepted.
  int          m_pos, m_n, m_words, m_idle;
  bit          m_done, m_err, e_wren;
  logic [1:0]  m_code;
  logic [31:0] m_acc, e_din;
  logic [7:0]  m_xor;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_n = 0; m_words = 0; m_idle = 0;
      m_done = 0; m_err = 0; e_wren = 0; m_code = 2'd0;
      m_acc = 0; e_din = 0; m_xor = 0;
    end else begin
      e_wren = 0;
      if (!m_done && !m_err) begin
        if (bus.rx_valid) begin
          m_idle = 0;
          if (m_pos == 0) begin
            m_n = int'(bus.rx_data) * 256;
          end else if (m_pos == 1) begin
            m_n = m_n + int'(bus.rx_data);
            if (m_n < 1 || m_n > MAXW) begin m_err = 1; m_code = 2'd1; end
          end else if (m_pos < 2 + 4 * m_n) begin
            m_xor = m_xor ^ bus.rx_data;
            m_acc = {m_acc[23:0], bus.rx_data};
            if ((m_pos - 2) % 4 == 3) begin
              e_wren = 1; e_din = m_acc; m_words++;
            end
          end else if (bus.rx_data == m_xor) begin
            m_done = 1;
          end else begin
            m_err = 1; m_code = 2'd2;
          end
          m_pos++;
        end else if (m_pos > 0) begin
          m_idle++;
          if (m_idle >= TMO) begin m_err = 1; m_code = 2'd3; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      bit exp_busy, ok;
      logic [ADDR_W-1:0] exp_addr;
      exp_busy = (m_pos > 0) && !m_done && !m_err;
      exp_addr = ADDR_W'(BASE + 4 * (m_words - int'(e_wren)));
      ok = (bus.wren == e_wren) && (bus.din == e_din) && (bus.busy == exp_busy) &&
           (bus.done == m_done) && (bus.error == m_err) && (bus.err_code == m_code) &&
           (bus.cpu_rst_n == m_done);
      if (e_wren || m_words == 0) ok = ok && (bus.addr == exp_addr);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL model t=%0t got/exp: wren %b/%b din %h/%h addr %h/%h busy %b/%b done %b/%b error %b/%b code %0d/%0d cpu_rst_n %b/%b",
                 $time, bus.wren, e_wren, bus.din, e_din, bus.addr, exp_addr, bus.busy, exp_busy,
                 bus.done, m_done, bus.error, m_err, bus.err_code, m_code, bus.cpu_rst_n, m_done);
      end
    end
  end

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  always @(negedge clk) if (rst_n && bus.wren) begin
    wa_q.push_back(bus.addr);
    wd_q.push_back(bus.din);
  end

  logic [7:0] fq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if ($urandom_range(0, 99) < 3) return int'($urandom_range(97, 102));
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send_q(input int mode);
    foreach (fq[i]) send_byte(fq[i], pick_gap(mode));
  endtask

  // Frame with n words; incr selects word k = k, else random bytes.
  task automatic build(input int n, input bit bad, input bit incr);
    logic [7:0]  ck;
    logic [31:0] w;
    fq.delete();
    fq.push_back(8'(n >> 8));
    fq.push_back(8'(n));
    if (n < 1 || n > MAXW) begin
      repeat (3) fq.push_back(8'($urandom));
      return;
    end
    ck = 8'd0;
    for (int k = 0; k < n; k++) begin
      w = incr ? 32'(k) : $urandom;
      for (int j = 3; j >= 0; j--) begin
        fq.push_back(w[8*j +: 8]);
        ck = ck ^ w[8*j +: 8];
      end
    end
    fq.push_back(bad ? (ck ^ 8'($urandom_range(1, 255))) : ck);
  endtask

  task automatic load_literal(input logic [7:0] ck);
    fq = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, ck};
    send_q(0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    checking = 1;
    do_reset();
    chk("rst_addr", 32'(bus.addr), 32'(BASE));
    chk("rst_din", bus.din, 0);
    chk("rst_flags", {bus.wren, bus.busy, bus.done, bus.error, bus.err_code, bus.cpu_rst_n}, 0);

    load_literal(8'h22);
    chk("t1_nwr", wa_q.size(), 2);
    chk("t1_a0", 32'(wa_q[0]), 32'h000);
    chk("t1_d0", wd_q[0], 32'hDEADBEEF);
    chk("t1_a1", 32'(wa_q[1]), 32'h004);
    chk("t1_d1", wd_q[1], 32'h01234567);
    chk("t1_done", {bus.done, bus.cpu_rst_n, bus.error}, 3'b110);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    repeat (2) @(negedge clk);
    chk("t1_ignore", {bus.done, 8'(wa_q.size())}, {1'b1, 8'd2});

    do_reset();
    load_literal(8'h23);
    chk("t2_nwr", wa_q.size(), 2);
    chk("t2_flags", {bus.error, bus.err_code, bus.done, bus.cpu_rst_n}, 5'b11000);

    do_reset();
    fq = '{8'h00, 8'h00, 8'h11, 8'h22};
    send_q(0);
    repeat (6) @(negedge clk);
    chk("cnt0", {bus.error, bus.err_code, 8'(wa_q.size())}, {3'b101, 8'd0});
    do_reset();
    fq = '{8'h08, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_q(0);
    repeat (2) @(negedge clk);
    chk("cnt2049", {bus.error, bus.err_code, 8'(wa_q.size())}, {3'b101, 8'd0});

    do_reset();
    fq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_q(0);
    repeat (99) @(negedge clk);
    chk("tmo_99", {bus.error, bus.busy}, 2'b01);
    @(negedge clk);
    chk("tmo_100", {bus.error, bus.err_code, bus.busy}, 4'b1110);
    chk("tmo_nwr", wa_q.size(), 0);

    do_reset();
    fq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_q(0);
    send_byte(8'hCC, 99);
    chk("tmo_edge", {bus.error, bus.busy}, 2'b01);
    send_byte(8'hDD, 0);
    send_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    chk("tmo_edge_done", {bus.done, bus.error}, 2'b10);
    chk("tmo_edge_din", wd_q.size() == 1 ? wd_q[0] : 32'hX, 32'hAABBCCDD);

    do_reset();
    fq = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send_q(0);
    do_reset();
    chk("mid_rst", {bus.din, 8'(bus.addr), bus.wren, bus.busy, bus.done, bus.error, bus.cpu_rst_n},
        {32'd0, 8'd0, 5'd0});
    load_literal(8'h22);
    chk("mid_reload", {bus.done, 8'(wa_q.size()), 8'(wa_q[0])}, {1'b1, 8'd2, 8'h00});

    do_reset();
    build(MAXW, 1'b0, 1'b1);
    send_q(0);
    repeat (2) @(negedge clk);
    chk("full_nwr", wa_q.size(), MAXW);
    chk("full_last", 32'(wa_q[MAXW-1]), 32'h1FFC);
    begin
      int zeros = 0;
      foreach (wa_q[i]) if (wa_q[i] == '0) zeros++;
      chk("full_zero_addr", zeros, 1);
    end
    chk("full_done", {bus.done, bus.cpu_rst_n}, 2'b11);

    for (int it = 0; it < 40; it++) begin
      int r, n;
      do_reset();
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? 0 : (r == 1) ? MAXW + 1 + int'($urandom_range(0, 99)) : int'($urandom_range(1, 6));
      build(n, $urandom_range(0, 3) == 0, 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        int keep = int'($urandom_range(1, fq.size()));
        while (fq.size() > keep) void'(fq.pop_back());
      end
      send_q(1);
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom), int'($urandom_range(0, 1)));
      repeat (3) @(negedge clk);
    end

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_loader.md
# bram_loader

Boot-time program loader sitting directly upstream of the BRAM write port. Consumes a byte stream from the UART receiver, assembles big-endian 32-bit words and writes them into consecutive word addresses of BRAM, verifying a trailing XOR checksum. Holds the CPU in reset until a frame has loaded and verified, then releases it.

## Interface
- ADDR_W, 13, BRAM byte-address width (matches BRAM `addr`)
- BASE_ADDR, 0, byte address of first word written; multiple of 4
- TIMEOUT_CYC, 1000000, max idle clocks between bytes inside a frame (20 ms at 50 MHz)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- rx_data  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  single-cycle strobe, one per byte
- addr  out  ADDR_W  BRAM byte address
- din  out  32  BRAM write data
- wren  out  1  BRAM write enable, single-cycle pulse per word
- busy  out  1  frame in progress (states CNT_LO..CHECK)
- done  out  1  frame loaded and checksum matched; sticky
- error  out  1  frame aborted; sticky
- err_code  out  2  00 none, 01 bad count, 10 checksum mismatch, 11 timeout
- cpu_rst_n  out  1  CPU reset, low until done=1

## Operation
- Frame: CNT_HI, CNT_LO (16-bit word count N, big-endian), 4·N data bytes, 1 checksum byte.
- Word assembly: first byte of each group -> din[31:24], last -> din[7:0].
- Checksum = XOR of all 4·N data bytes (count bytes excluded).
- MAX_WORDS = (2^ADDR_W − BASE_ADDR)/4; valid N is 1..MAX_WORDS.
- States:
  - IDLE: wait for rx_valid; latch count high byte -> CNT_LO.
  - CNT_LO: on rx_valid latch low byte; N=0 or N>MAX_WORDS -> ERROR (code 01), else -> DATA.
  - DATA: shift byte into 32-bit word, XOR into checksum, byte index 0..3; on 4th byte, write word; after word N -> CHECK.
  - CHECK: on rx_valid compare; match -> DONE, mismatch -> ERROR (code 10).
  - DONE: done=1, cpu_rst_n=1; all further rx_valid ignored until reset.
  - ERROR: error=1, err_code held, cpu_rst_n=0; rx_valid ignored until reset.
- Timeout counter: cleared on every rx_valid and in IDLE/DONE/ERROR; increments each clock in CNT_LO, DATA, CHECK without rx_valid; reaching TIMEOUT_CYC -> ERROR (code 11).
- Address: first write at BASE_ADDR, +4 per word; no wrap (count check guarantees last address ≤ 2^ADDR_W − 4).
- Checksum mismatch and timeout do not undo writes already made.

## Timing
- Reset values: addr=BASE_ADDR, din=0, wren=0, busy=0, done=0, error=0, err_code=00, cpu_rst_n=0, state IDLE, counters 0.
- Write latency: on the edge sampling the 4th byte of a word, addr/din are registered and wren=1 for exactly the following cycle; addr advances by 4 on the edge ending that wren cycle.
- din and addr stable throughout the wren cycle; din holds last word otherwise.
- Back-to-back rx_valid on consecutive cycles supported; wren pulses never overlap since ≥4 bytes per word.
- done/error and cpu_rst_n change on the edge that samples the checksum byte (or detects the fault); visible next cycle.
- Timeout: error asserts after TIMEOUT_CYC consecutive clocks without rx_valid in a busy state.
- rx_valid in the same cycle the counter would reach TIMEOUT_CYC: byte is accepted, no timeout.
- rst_n low mid-frame: all outputs return to reset values on that edge; wren in flight is dropped; BRAM contents already written are not cleared.

## Test plan
- N=2, bytes 00 02 DE AD BE EF 01 23 45 67 22 -> wren at addr 0x000 din 0xDEADBEEF, then addr 0x004 din 0x01234567; done=1, cpu_rst_n=1, error=0.
- Same frame, checksum 0x23 -> both writes occur; error=1, err_code=10, done=0, cpu_rst_n=0.
- Count 00 00, and separately 08 01 (2049, BASE_ADDR=0) -> error=1, err_code=01, no wren pulse.
- TIMEOUT_CYC=100: send 00 01 AA BB then silence -> error=1, err_code=11 exactly 100 clocks after the BB strobe; no wren; a byte arriving on clock 100 instead prevents the timeout.
- rst_n low for one cycle after 5 data bytes of an N=2 frame -> all outputs at reset values; then full valid frame loads from addr 0x000 and done=1.
- N=2048 with incrementing data -> 2048 wren pulses, last at addr 0x1FFC, no write to 0x000 after the first; done=1.
